loom_axil_regfile: RTL

- AXI-Lite slave register file that sits directly downstream of one master port of the AXI-Lite 1:N demux.
- It receives base-relative addresses and provides N_REGS 32-bit control/status registers to local logic.
- Each register is either software read-write (RW) or hardware-driven read-only (RO).
- It returns exactly one response per accepted address, which the demux's in-progress tracking requires.

---
 rtl/loom_axil_regfile_if.sv | 37 +++
 rtl/loom_axil_regfile.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/loom_axil_regfile_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | loom_axil_regfile_if : AXI-Lite bus bundle between the demux and regfile.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface loom_axil_regfile_if #(
    parameter int ADDR_WIDTH = 20
);
    logic [ADDR_WIDTH-1:0] araddr;
    logic                  arvalid;
    logic                  arready;
    logic [31:0]           rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic                  awvalid;
    logic                  awready;
    logic [31:0]           wdata;
    logic [3:0]            wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    modport master (
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );
endinterface
`default_nettype wire

// File: rtl/loom_axil_regfile.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | loom_axil_regfile : AXI-Lite slave with N_REGS RW/RO 32-bit registers.     |
// | Optional: LOOM_AXIL_REGFILE_ERR_EN (SLVERR + DEAD_BEEF on misses/RO writes) |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module loom_axil_regfile #(
    parameter int                      ADDR_WIDTH = 20,
    parameter int                      N_REGS     = 16,
    parameter logic [N_REGS-1:0]       RO_MASK    = '0,
    parameter logic [N_REGS-1:0][31:0] RESET_VAL  = '0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    loom_axil_regfile_if.slave      s_axil,
    output logic [N_REGS*32-1:0]    reg_q_o,
    input  logic [N_REGS*32-1:0]    hw_rdata_i,
    output logic [N_REGS-1:0]       reg_wr_pulse_o
);

    localparam int                  c_idx_w       = ADDR_WIDTH - 2;
    localparam logic [c_idx_w:0]    c_n_regs      = (c_idx_w + 1)'(N_REGS);
    localparam logic [1:0]          c_resp_okay   = 2'b00;
    localparam logic [1:0]          c_resp_slverr = 2'b10;
`ifdef LOOM_AXIL_REGFILE_ERR_EN
    localparam logic                c_err_en      = 1'b1;
`else
    localparam logic                c_err_en      = 1'b0;
`endif
    localparam logic [1:0]          c_err_resp    = c_err_en ? c_resp_slverr : c_resp_okay;
    localparam logic [31:0]         c_miss_rdata  = c_err_en ? 32'hDEAD_BEEF : 32'h0000_0000;

    localparam logic [0:0] W_IDLE = 1'b0;
    localparam logic [0:0] W_RESP = 1'b1;
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    // Address decode; index compared at full width so high bits never alias.
    logic [c_idx_w-1:0] w_ar_idx, w_aw_idx;
    logic               w_ar_hit, w_aw_hit;

    assign w_ar_idx = s_axil.araddr[ADDR_WIDTH-1:2];
    assign w_aw_idx = s_axil.awaddr[ADDR_WIDTH-1:2];
    assign w_ar_hit = (s_axil.araddr[1:0] == 2'b00) && ({1'b0, w_ar_idx} < c_n_regs);
    assign w_aw_hit = (s_axil.awaddr[1:0] == 2'b00) && ({1'b0, w_aw_idx} < c_n_regs);

    logic [31:0] w_q [N_REGS];
    logic [31:0] w_ar_val;
    logic        w_aw_ro;

    always_comb begin
        w_ar_val = '0;
        w_aw_ro  = 1'b0;
        for (int i = 0; i < N_REGS; i++) begin
            if (w_ar_idx == c_idx_w'(i)) w_ar_val = w_q[i];
            if (w_aw_idx == c_idx_w'(i)) w_aw_ro  = RO_MASK[i];
        end
    end

    // ---------------- write FSM ----------------
    logic [0:0] r_wstate, w_wstate_nxt;
    logic       w_aw_acc, w_bvalid;
    logic [1:0] r_bresp;

    always_ff @(posedge clk_i) begin
        if (rst_i) r_wstate <= W_IDLE;
        else       r_wstate <= w_wstate_nxt;
    end

    always_comb begin
        w_wstate_nxt = r_wstate;
        case (r_wstate)
            W_IDLE:  if (w_aw_acc)      w_wstate_nxt = W_RESP;
            W_RESP:  if (s_axil.bready) w_wstate_nxt = W_IDLE;
            default:                    w_wstate_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        w_aw_acc = (r_wstate == W_IDLE) && s_axil.awvalid && s_axil.wvalid && !rst_i;
        w_bvalid = (r_wstate == W_RESP);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)         r_bresp <= c_resp_okay;
        else if (w_aw_acc) r_bresp <= (!w_aw_hit || w_aw_ro) ? c_err_resp : c_resp_okay;
    end

    assign s_axil.awready = w_aw_acc;
    assign s_axil.wready  = w_aw_acc;
    assign s_axil.bvalid  = w_bvalid;
    assign s_axil.bresp   = r_bresp;

    // ---------------- read FSM ----------------
    logic [0:0]  r_rstate, w_rstate_nxt;
    logic        w_ar_acc, w_arready, w_rvalid;
    logic [31:0] r_rdata;
    logic [1:0]  r_rresp;

    always_ff @(posedge clk_i) begin
        if (rst_i) r_rstate <= R_IDLE;
        else       r_rstate <= w_rstate_nxt;
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            R_IDLE:  if (w_ar_acc)      w_rstate_nxt = R_DATA;
            R_DATA:  if (s_axil.rready) w_rstate_nxt = R_IDLE;
            default:                    w_rstate_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        w_arready = (r_rstate == R_IDLE) && !rst_i;
        w_ar_acc  = w_arready && s_axil.arvalid;
        w_rvalid  = (r_rstate == R_DATA);
    end

    // Read data is captured before any same-cycle write lands, so it returns the old value.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rdata <= '0;
            r_rresp <= c_resp_okay;
        end else if (w_ar_acc) begin
            r_rdata <= w_ar_hit ? w_ar_val : c_miss_rdata;
            r_rresp <= w_ar_hit ? c_resp_okay : c_err_resp;
        end
    end

    assign s_axil.arready = w_arready;
    assign s_axil.rvalid  = w_rvalid;
    assign s_axil.rdata   = r_rdata;
    assign s_axil.rresp   = r_rresp;

    // ---------------- register storage ----------------
    generate
        for (genvar gi = 0; gi < N_REGS; gi++) begin : g_reg
            localparam logic [c_idx_w-1:0] c_idx = c_idx_w'(gi);
            if (RO_MASK[gi]) begin : g_ro
                assign w_q[gi]            = hw_rdata_i[gi*32 +: 32];
                assign reg_wr_pulse_o[gi] = 1'b0;
            end else begin : g_rw
                logic [31:0] r_q;
                logic        r_pulse;
                logic        w_sel;
                logic        w_unused_hw;

                assign w_sel       = w_aw_acc && w_aw_hit && (w_aw_idx == c_idx);
                assign w_unused_hw = ^hw_rdata_i[gi*32 +: 32];

                always_ff @(posedge clk_i) begin
                    if (rst_i) begin
                        r_q     <= RESET_VAL[gi];
                        r_pulse <= 1'b0;
                    end else begin
                        r_pulse <= w_sel;
                        if (w_sel) begin
                            for (int b = 0; b < 4; b++) begin
                                if (s_axil.wstrb[b]) r_q[8*b +: 8] <= s_axil.wdata[8*b +: 8];
                            end
                        end
                    end
                end

                assign w_q[gi]            = r_q;
                assign reg_wr_pulse_o[gi] = r_pulse;
            end
            assign reg_q_o[gi*32 +: 32] = w_q[gi];
        end
    endgenerate

endmodule
`default_nettype wire
